// File: rtl/calc_sequencer.sv
// Operand/opcode sequencer with a registered ALU, sitting behind the keypad/cursor bank.
// Walks A -> B -> op -> calc -> result and feeds its state code back to the bank.
module calc_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE,
  input  logic             CLR,
  input  logic             CE,
  input  logic [WIDTH-1:0] op,
  output logic [2:0]       state,
  output logic             rst_s,
  output logic [WIDTH-1:0] disp,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5);
  localparam logic [OPW-1:0] OP_SHR = OPW'(6);

  state_t           state_reg, state_next;
  logic             exe_q_reg;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next, res_reg, res_next;
  logic [OPW-1:0]   opc_reg, opc_next;
  logic             carry_reg, carry_next, ovf_reg, ovf_next;
  logic             zero_reg, zero_next, err_reg, err_next;
  logic             busy_reg, busy_next, rst_s_reg, rst_s_next;
  logic             rst_s_req, exe_ev;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_e;

  assign exe_ev = EXE & ~exe_q_reg;

  always_comb begin
    sum   = {1'b0, a_reg} + {1'b0, b_reg};
    diff  = {1'b0, a_reg} - {1'b0, b_reg};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (opc_reg)
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        // the extra top bit of the widened difference is the unsigned borrow
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) & (diff[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND:  alu_r = a_reg & b_reg;
      OP_OR:   alu_r = a_reg | b_reg;
      OP_XOR:  alu_r = a_reg ^ b_reg;
      OP_SHL:  alu_r = a_reg << b_reg[3:0];
      OP_SHR:  alu_r = a_reg >> b_reg[3:0];
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    opc_next   = opc_reg;
    res_next   = res_reg;
    carry_next = carry_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;
    err_next   = err_reg;
    busy_next  = 1'b0;
    rst_s_req  = 1'b0;
    if (CLR) begin
      state_next = S_A;
      a_next     = '0;
      b_next     = '0;
      opc_next   = '0;
      res_next   = '0;
      carry_next = 1'b0;
      ovf_next   = 1'b0;
      zero_next  = 1'b0;
      err_next   = 1'b0;
      rst_s_req  = 1'b1;
    end else begin
      case (state_reg)
        S_A: if (!CE && exe_ev) begin
          a_next     = op;
          state_next = S_B;
          rst_s_req  = 1'b1;
        end
        S_B: if (!CE && exe_ev) begin
          b_next     = op;
          state_next = S_OP;
          rst_s_req  = 1'b1;
        end
        S_OP: if (!CE && exe_ev) begin
          opc_next   = op[OPW-1:0];
          state_next = S_CALC;
          busy_next  = 1'b1;
        end
        S_CALC: begin
          res_next   = alu_r;
          carry_next = alu_c;
          ovf_next   = alu_v;
          zero_next  = (alu_r == '0);
          err_next   = alu_e;
          state_next = S_RES;
          rst_s_req  = 1'b1;
        end
        S_RES: begin
          if (CE) begin
            res_next   = '0;
            carry_next = 1'b0;
            ovf_next   = 1'b0;
            zero_next  = 1'b0;
            err_next   = 1'b0;
          end else if (exe_ev) begin
            a_next     = res_reg;
            state_next = S_B;
            rst_s_req  = 1'b1;
          end
        end
        default: begin
          state_next = S_A;
          rst_s_req  = 1'b1;
        end
      endcase
    end
    // a held CLR must not stretch the bank clear beyond one cycle
    rst_s_next = rst_s_req & ~rst_s_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_A;
      exe_q_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      opc_reg   <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      rst_s_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      exe_q_reg <= EXE;
      a_reg     <= a_next;
      b_reg     <= b_next;
      opc_reg   <= opc_next;
      res_reg   <= res_next;
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      rst_s_reg <= rst_s_next;
    end
  end

  assign state = state_reg;
  assign rst_s = rst_s_reg;
  assign busy  = busy_reg;
  assign carry = carry_reg;
  assign ovf   = ovf_reg;
  assign zero  = zero_reg;
  assign err   = err_reg;
  assign disp  = (state_reg == S_RES || state_reg == S_CALC) ? res_reg : op;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues the expected outputs for each
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_calc_sequencer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, EXE, CLR, CE;
  logic [W-1:0]  op;
  logic [2:0]    state;
  logic          rst_s, carry, ovf, zero, err, busy;
  logic [W-1:0]  disp;

  calc_sequencer #(.WIDTH(W), .OPW(5)) dut (
    .clk(clk), .rst(rst), .EXE(EXE), .CLR(CLR), .CE(CE), .op(op),
    .state(state), .rst_s(rst_s), .disp(disp), .carry(carry), .ovf(ovf),
    .zero(zero), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         at;
    logic [2:0] st;
    logic [W-1:0] dsp;
    logic [3:0] flg;   // {carry, ovf, zero, err}
    logic       bsy;
    logic       rs;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      exp_t e;
      logic [3:0] f;
      e = sbq.pop_front();
      f = {carry, ovf, zero, err};
      checks++;
      if (e.at != cyc) begin
        failures++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.nm, e.at, cyc);
      end else if (state !== e.st || disp !== e.dsp || f !== e.flg || busy !== e.bsy || rst_s !== e.rs) begin
        failures++;
        $display("FAIL %s: got st=%0d disp=%h cozE=%b busy=%b rst_s=%b, want st=%0d disp=%h cozE=%b busy=%b rst_s=%b",
                 e.nm, state, disp, f, busy, rst_s, e.st, e.dsp, e.flg, e.bsy, e.rs);
      end else begin
        $display("ok   %s: st=%0d disp=%h cozE=%b busy=%b rst_s=%b", e.nm, state, disp, f, busy, rst_s);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and queue the outputs expected during that same cycle.
  task automatic cycle(input logic e, input logic cl, input logic ce, input logic [W-1:0] o,
                       input logic [2:0] st, input logic [W-1:0] dsp, input logic [3:0] flg,
                       input logic bsy, input logic rs, input string nm);
    exp_t x;
    EXE = e; CLR = cl; CE = ce; op = o;
    x.nm = nm; x.at = cyc; x.st = st; x.dsp = dsp; x.flg = flg; x.bsy = bsy; x.rs = rs;
    sbq.push_back(x);
    step();
  endtask

  // From S_A with result/flags cleared: load A and B, leaving the DUT in S_OP (rst_s high).
  task automatic to_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string nm);
    cycle(1, 0, 0, av, 3'd0, av, 4'b0, 0, 0, {nm, "_exeA"});
    cycle(0, 0, 0, av, 3'd1, av, 4'b0, 0, 1, {nm, "_inB"});
    cycle(1, 0, 0, bv, 3'd1, bv, 4'b0, 0, 0, {nm, "_exeB"});
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [4:0] oc,
                        input logic [W-1:0] r, input logic [3:0] f, input string nm);
    logic [W-1:0] ocv;
    ocv = {11'b0, oc};
    to_op(av, bv, nm);
    cycle(0, 0, 0, ocv, 3'd2, ocv, 4'b0, 0, 1, {nm, "_inOP"});
    cycle(1, 0, 0, ocv, 3'd2, ocv, 4'b0, 0, 0, {nm, "_exeOP"});
    cycle(0, 0, 0, ocv, 3'd3, '0,  4'b0, 1, 0, {nm, "_calc"});
    cycle(0, 0, 0, ocv, 3'd4, r,   f,    0, 1, {nm, "_res"});
  endtask

  task automatic do_clr(input string nm);
    EXE = 0; CLR = 1; CE = 0; op = '0;
    step();
    cycle(0, 0, 0, '0, 3'd0, '0, 4'b0, 0, 1, {nm, "_clr"});
    cycle(0, 0, 0, '0, 3'd0, '0, 4'b0, 0, 0, {nm, "_idle"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; EXE = 0; CLR = 0; CE = 0; op = '0;
    step(); step();
    rst = 0;
    cycle(0, 0, 0, 16'd25, 3'd0, 16'd25, 4'b0, 0, 0, "reset");

    // 25 + 17
    run_op(16'd25, 16'd17, 5'd0, 16'd42, 4'b0000, "add42");
    do_clr("c1");
    // signed overflow on ADD
    run_op(16'h7FFF, 16'h0001, 5'd0, 16'h8000, 4'b0100, "addovf");
    do_clr("c2");
    // SUB with borrow
    run_op(16'h0003, 16'h0005, 5'd1, 16'hFFFE, 4'b1000, "subbor");
    do_clr("c3");
    // undefined op code, then chain an AND from S_RES
    run_op(16'h0003, 16'h0005, 5'd9, 16'h0000, 4'b0011, "undef");
    cycle(0, 0, 0, 16'h0,  3'd4, 16'h0,  4'b0011, 0, 0, "ch_hold");
    cycle(1, 0, 0, 16'h0,  3'd4, 16'h0,  4'b0011, 0, 0, "ch_exeRES");
    cycle(0, 0, 0, 16'hF0, 3'd1, 16'hF0, 4'b0011, 0, 1, "ch_inB");
    cycle(1, 0, 0, 16'hF0, 3'd1, 16'hF0, 4'b0011, 0, 0, "ch_exeB");
    cycle(0, 0, 0, 16'h2,  3'd2, 16'h2,  4'b0011, 0, 1, "ch_inOP");
    cycle(1, 0, 0, 16'h2,  3'd2, 16'h2,  4'b0011, 0, 0, "ch_exeOP");
    cycle(0, 0, 0, 16'h2,  3'd3, 16'h0,  4'b0011, 1, 0, "ch_calc");
    cycle(0, 0, 0, 16'h2,  3'd4, 16'h0,  4'b0010, 0, 1, "ch_res");
    do_clr("c4");

    // EXE held for 10 cycles: one event only; then 5 + 3 proves A = 5
    for (int i = 0; i < 10; i++)
      cycle(1, 0, 0, 16'd5, (i == 0) ? 3'd0 : 3'd1, 16'd5, 4'b0, 0, (i == 1), "hold");
    cycle(0, 0, 0, 16'd5, 3'd1, 16'd5, 4'b0, 0, 0, "hold_rel");
    cycle(1, 0, 0, 16'd3, 3'd1, 16'd3, 4'b0, 0, 0, "hold_exeB");
    cycle(0, 0, 0, 16'd0, 3'd2, 16'd0, 4'b0, 0, 1, "hold_inOP");
    cycle(1, 0, 0, 16'd0, 3'd2, 16'd0, 4'b0, 0, 0, "hold_exeOP");
    cycle(0, 0, 0, 16'd0, 3'd3, 16'd0, 4'b0, 1, 0, "hold_calc");
    cycle(0, 0, 0, 16'd0, 3'd4, 16'd8, 4'b0, 0, 1, "hold_res8");
    do_clr("c5");

    // CLR together with EXE in S_OP
    to_op(16'd1, 16'd2, "clrop");
    cycle(0, 0, 0, 16'd0, 3'd2, 16'd0, 4'b0, 0, 1, "clrop_inOP");
    cycle(1, 1, 0, 16'd0, 3'd2, 16'd0, 4'b0, 0, 0, "clrop_both");
    cycle(0, 0, 0, 16'd0, 3'd0, 16'd0, 4'b0, 0, 1, "clrop_sa");
    cycle(0, 0, 0, 16'd0, 3'd0, 16'd0, 4'b0, 0, 0, "clrop_nobusy");

    // CE in S_RES clears result, then CE + EXE stays put
    run_op(16'd25, 16'd17, 5'd0, 16'd42, 4'b0000, "ce42");
    cycle(0, 0, 1, 16'd0, 3'd4, 16'd42, 4'b0, 0, 0, "ce_apply");
    cycle(0, 0, 0, 16'd0, 3'd4, 16'd0,  4'b0, 0, 0, "ce_cleared");
    cycle(1, 0, 1, 16'd0, 3'd4, 16'd0,  4'b0, 0, 0, "ce_exe");
    cycle(0, 0, 0, 16'd0, 3'd4, 16'd0,  4'b0, 0, 0, "ce_stay");
    do_clr("c6");

    // rst during S_CALC
    to_op(16'd25, 16'd17, "rstc");
    cycle(0, 0, 0, 16'd0, 3'd2, 16'd0, 4'b0, 0, 1, "rstc_inOP");
    cycle(1, 0, 0, 16'd0, 3'd2, 16'd0, 4'b0, 0, 0, "rstc_exeOP");
    rst = 1;
    cycle(0, 0, 0, 16'd0, 3'd3, 16'd0, 4'b0, 1, 0, "rstc_calc");
    rst = 0;
    cycle(0, 0, 0, 16'd0, 3'd0, 16'd0, 4'b0, 0, 0, "rstc_after");
    cycle(0, 0, 0, 16'd0, 3'd0, 16'd0, 4'b0, 0, 0, "rstc_idle");

    @(negedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
